jtdd_rom_arb: RTL

- Shares one SDRAM read port between three ROM consumers: main CPU (6809), sound CPU and MCU.
- Each consumer sees a simple cs/addr/dout/ok port. The block adds a per-region offset, arbitrates round-robin and runs the SDRAM req/ack/rdy handshake.
- Each consumer has a one-word (32-bit) cache, so sequential opcode fetches hit without SDRAM traffic.
- Sits between the CPU/MCU wrappers and the frame SDRAM controller.

---
 rtl/jtdd_pkg.sv | 28 ++
 rtl/jtdd_rom_slot.sv | 64 ++++++
 rtl/jtdd_rom_arb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/jtdd_pkg.sv
// Shared constants for the JTDD ROM arbiter: requester indices,
// arbiter state encoding and default ROM region offsets.
package jtdd_pkg;

   localparam int NREQ = 3;

   // Requester indices; round-robin order is main -> snd -> mcu -> main
   localparam logic [1:0] REQ_MAIN = 2'd0;
   localparam logic [1:0] REQ_SND  = 2'd1;
   localparam logic [1:0] REQ_MCU  = 2'd2;

   // Default byte bases of each ROM region inside SDRAM
   localparam logic [21:0] MAIN_OFFSET_DEF = 22'h00_0000;
   localparam logic [21:0] SND_OFFSET_DEF  = 22'h04_0000;
   localparam logic [21:0] MCU_OFFSET_DEF  = 22'h04_8000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_RDY = 2'd2
   } arb_state_t;

   // Requester that follows idx in round-robin order
   function automatic logic [1:0] req_next(input logic [1:0] idx);
      return (idx == REQ_MCU) ? REQ_MAIN : idx + 2'd1;
   endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One requester slot: region offset add, one-word cache, hit detect,
// little-endian byte select and pending flag for the arbiter.
module jtdd_rom_slot
   import jtdd_pkg::*;
#(
   parameter int             AW     = 22,
   parameter int             LAW    = 18,
   parameter logic [AW-1:0]  OFFSET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             downloading,
   input  logic             cs,
   input  logic [LAW-1:0]   addr,
   input  logic             fill,
   input  logic [AW-3:0]    fill_tag,
   input  logic [31:0]      fill_data,
   output logic [AW-1:0]    full_addr,
   output logic [7:0]       dout,
   output logic             ok,
   output logic             pending
);

   logic          valid_reg;
   logic [AW-3:0] tag_reg;
   logic [31:0]   data_reg;
   logic          hit;

   // Region-relative address; carry out of the top bit is dropped
   assign full_addr = OFFSET + AW'(addr);

   // Hit depends only on cached state and the requester inputs
   assign hit     = cs & valid_reg & (tag_reg == full_addr[AW-1:2]);
   assign ok      = hit;
   assign pending = cs & ~hit & ~downloading;

   // Byte lane select, byte 0 in bits 7:0
   always_comb begin
      dout = data_reg[7:0];
      case (addr[1:0])
         2'd0: dout = data_reg[7:0];
         2'd1: dout = data_reg[15:8];
         2'd2: dout = data_reg[23:16];
         2'd3: dout = data_reg[31:24];
         default: dout = data_reg[7:0];
      endcase
   end

   // Cache entry update: downloading flushes and overrides any fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         tag_reg   <= '0;
         data_reg  <= '0;
      end else if (downloading) begin
         valid_reg <= 1'b0;
      end else if (fill) begin
         valid_reg <= 1'b1;
         tag_reg   <= fill_tag;
         data_reg  <= fill_data;
      end
   end

endmodule

// File: rtl/jtdd_rom_arb.sv
// Shares one SDRAM read port between main CPU, sound CPU and MCU ROM
// ports. Round-robin arbitration, req/ack/rdy handshake, and a one-word
// cache per requester held in jtdd_rom_slot.
module jtdd_rom_arb
   import jtdd_pkg::*;
#(
   parameter int            AW          = 22,
   parameter logic [AW-1:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
   parameter logic [AW-1:0] SND_OFFSET  = SND_OFFSET_DEF,
   parameter logic [AW-1:0] MCU_OFFSET  = MCU_OFFSET_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           downloading,
   input  logic           main_cs,
   input  logic [17:0]    main_addr,
   output logic [7:0]     main_dout,
   output logic           main_ok,
   input  logic           snd_cs,
   input  logic [14:0]    snd_addr,
   output logic [7:0]     snd_dout,
   output logic           snd_ok,
   input  logic           mcu_cs,
   input  logic [13:0]    mcu_addr,
   output logic [7:0]     mcu_dout,
   output logic           mcu_ok,
   output logic           sdram_req,
   output logic [AW-1:0]  sdram_addr,
   input  logic           sdram_ack,
   input  logic           sdram_rdy,
   input  logic [31:0]    sdram_data
);

   localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

   arb_state_t    state_reg, state_next;
   logic [1:0]    ptr_reg, ptr_next;
   logic [1:0]    gnt_reg, gnt_next;
   logic          sdram_req_reg, sdram_req_next;
   logic [AW-1:0] sdram_addr_reg, sdram_addr_next;

   logic [NREQ-1:0] cs_vec;
   logic [NREQ-1:0] pend_vec;
   logic [NREQ-1:0] ok_vec;
   logic [17:0]     loc_addr  [NREQ];
   logic [AW-1:0]   slot_full [NREQ];
   logic [7:0]      slot_dout [NREQ];

   logic            fill_en;
   logic            pick_found;
   logic [1:0]      pick_idx;
   logic [1:0]      scan_idx;

   assign cs_vec            = {mcu_cs, snd_cs, main_cs};
   assign loc_addr[REQ_MAIN] = main_addr;
   assign loc_addr[REQ_SND]  = {3'b000, snd_addr};
   assign loc_addr[REQ_MCU]  = {4'b0000, mcu_addr};

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slot
         jtdd_rom_slot #(
            .AW     (AW),
            .LAW    (18),
            .OFFSET (gi == 0 ? MAIN_OFFSET : (gi == 1 ? SND_OFFSET : MCU_OFFSET))
         ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .downloading (downloading),
            .cs          (cs_vec[gi]),
            .addr        (loc_addr[gi]),
            .fill        (fill_en && (gnt_reg == 2'(gi))),
            .fill_tag    (sdram_addr_reg[AW-1:2]),
            .fill_data   (sdram_data),
            .full_addr   (slot_full[gi]),
            .dout        (slot_dout[gi]),
            .ok          (ok_vec[gi]),
            .pending     (pend_vec[gi])
         );
      end
   endgenerate

   assign main_dout  = slot_dout[REQ_MAIN];
   assign snd_dout   = slot_dout[REQ_SND];
   assign mcu_dout   = slot_dout[REQ_MCU];
   assign main_ok    = ok_vec[REQ_MAIN];
   assign snd_ok     = ok_vec[REQ_SND];
   assign mcu_ok     = ok_vec[REQ_MCU];
   assign sdram_req  = sdram_req_reg;
   assign sdram_addr = sdram_addr_reg;

   // Round-robin scan: first pending requester starting at the pointer
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_reg;
      scan_idx   = ptr_reg;
      for (int k = 0; k < NREQ; k++) begin
         if (!pick_found && pend_vec[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
         scan_idx = req_next(scan_idx);
      end
   end

   // Next-state logic: grant, handshake with SDRAM, cache fill strobe
   always_comb begin
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      gnt_next        = gnt_reg;
      sdram_req_next  = sdram_req_reg;
      sdram_addr_next = sdram_addr_reg;
      fill_en         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               gnt_next        = pick_idx;
               sdram_addr_next = slot_full[pick_idx] & WORD_MASK;
               sdram_req_next  = 1'b1;
               ptr_next        = req_next(pick_idx);
               state_next      = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (sdram_ack) begin
               sdram_req_next = 1'b0;
               if (sdram_rdy) begin
                  // Data arrived together with the ack
                  fill_en    = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WAIT_RDY;
               end
            end
         end
         WAIT_RDY: begin
            if (sdram_rdy) begin
               fill_en    = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            sdram_req_next = 1'b0;
            state_next     = IDLE;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         ptr_reg        <= REQ_MAIN;
         gnt_reg        <= REQ_MAIN;
         sdram_req_reg  <= 1'b0;
         sdram_addr_reg <= '0;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         gnt_reg        <= gnt_next;
         sdram_req_reg  <= sdram_req_next;
         sdram_addr_reg <= sdram_addr_next;
      end
   end

endmodule
